// File: rtl/lab02_pkg.sv
// Shared types and sizes for the truth-table scanner.
package lab02_pkg;

  localparam int N_VEC = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/lab02_settle_cnt.sv
// Loadable down-counter; term_o flags the last settle cycle (count == 1).
module lab02_settle_cnt
  import lab02_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/lab02_truth_scanner.sv
// Sweeps {A,B,C,D} over 0..15, samples Y after SETTLE cycles per vector and
// builds a 16-bit truth table with ones count and first/last set index.
module lab02_truth_scanner
  import lab02_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic             d_o,
  input  logic             y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [N_VEC-1:0] table_o,
  output logic [4:0]       ones_o,
  output logic             any_one_o,
  output logic [IDX_W-1:0] first_idx_o,
  output logic [IDX_W-1:0] last_idx_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_VEC-1:0] table_q, table_d;
  logic [4:0]       ones_q, ones_d;
  logic             any_q, any_d;
  logic [IDX_W-1:0] first_q, first_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic in_sweep;
  logic start_go;
  logic cnt_load;
  logic cnt_term;

  assign in_sweep = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign start_go = (state_q == ST_IDLE) && start_i;
  // Reload on acceptance and whenever SAMPLE hands over to the next vector.
  assign cnt_load = start_go || ((state_q == ST_SAMPLE) && !abort_i);

  lab02_settle_cnt u_settle_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .load_val_i(CNT_W'(SETTLE)),
    .dec_i     (state_q == ST_SETTLE),
    .term_o    (cnt_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (abort_i)       state_d = ST_IDLE;
        else if (cnt_term) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort_i)                           state_d = ST_IDLE;
        else if (idx_q == IDX_W'(N_VEC - 1))   state_d = ST_DONE;
        else                                   state_d = ST_SETTLE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    {a_o, b_o, c_o, d_o} = in_sweep ? idx_q : '0;
    busy_o = in_sweep;
    done_o = (state_q == ST_DONE);
  end

  // Abort wins over a capture in the same SAMPLE cycle.
  always_comb begin
    idx_d   = idx_q;
    table_d = table_q;
    ones_d  = ones_q;
    any_d   = any_q;
    first_d = first_q;
    last_d  = last_q;
    if (start_go || (in_sweep && abort_i)) begin
      idx_d   = '0;
      table_d = '0;
      ones_d  = '0;
      any_d   = 1'b0;
      first_d = '0;
      last_d  = '0;
    end else if (state_q == ST_SAMPLE) begin
      table_d[idx_q] = y_i;
      ones_d         = ones_q + 5'(y_i);
      if (y_i) begin
        if (!any_q) begin
          first_d = idx_q;
          any_d   = 1'b1;
        end
        last_d = idx_q;
      end
      if (idx_q != IDX_W'(N_VEC - 1)) begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      table_q <= '0;
      ones_q  <= '0;
      any_q   <= 1'b0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      idx_q   <= idx_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      any_q   <= any_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign table_o     = table_q;
  assign ones_o      = ones_q;
  assign any_one_o   = any_q;
  assign first_idx_o = first_q;
  assign last_idx_o  = last_q;

endmodule

// File: tb/tb_lab02_truth_scanner.sv
// Bench for lab02_truth_scanner: two instances (SETTLE=1 and SETTLE=3) driven in parallel.
module tb_lab02_truth_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [15:0] func = '0;
  bit use_expr = 1'b0;

  logic a1, b1, c1, d1, y1, busy1, done1, any1;
  logic a3, b3, c3, d3, y3, busy3, done3, any3;
  logic [15:0] tab1, tab3;
  logic [4:0] ones1, ones3;
  logic [3:0] first1, last1, first3, last3;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  assign y1 = use_expr ? (!(a1 | b1) & !(c1 & d1)) : func[{a1, b1, c1, d1}];
  assign y3 = use_expr ? (!(a3 | b3) & !(c3 & d3)) : func[{a3, b3, c3, d3}];

  lab02_truth_scanner #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .a_o(a1), .b_o(b1), .c_o(c1), .d_o(d1), .y_i(y1),
    .busy_o(busy1), .done_o(done1), .table_o(tab1), .ones_o(ones1),
    .any_one_o(any1), .first_idx_o(first1), .last_idx_o(last1)
  );

  lab02_truth_scanner #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .a_o(a3), .b_o(b3), .c_o(c3), .d_o(d3), .y_i(y3),
    .busy_o(busy3), .done_o(done3), .table_o(tab3), .ones_o(ones3),
    .any_one_o(any3), .first_idx_o(first3), .last_idx_o(last3)
  );

  typedef struct {
    string       name;
    logic [15:0] f;
    bit          expr;
    logic [15:0] t;
    logic [4:0]  o;
    logic        a;
    logic [3:0]  fi;
    logic [3:0]  la;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_results(input string tag, input logic [15:0] t, input logic [4:0] o,
                               input logic a, input logic [3:0] fi, input logic [3:0] la);
    check({tag, " s1 table"}, 32'(tab1), 32'(t));
    check({tag, " s1 ones"}, 32'(ones1), 32'(o));
    check({tag, " s1 any"}, 32'(any1), 32'(a));
    check({tag, " s1 first"}, 32'(first1), 32'(fi));
    check({tag, " s1 last"}, 32'(last1), 32'(la));
    check({tag, " s3 table"}, 32'(tab3), 32'(t));
    check({tag, " s3 ones"}, 32'(ones3), 32'(o));
    check({tag, " s3 any"}, 32'(any3), 32'(a));
    check({tag, " s3 first"}, 32'(first3), 32'(fi));
    check({tag, " s3 last"}, 32'(last3), 32'(la));
  endtask

  // Reference: the captured table is simply the truth function itself.
  function automatic void model(input logic [15:0] f, output logic [15:0] t, output logic [4:0] o,
                                output logic a, output logic [3:0] fi, output logic [3:0] la);
    t  = f;
    o  = 5'($countones(f));
    a  = (f != 16'h0);
    fi = 4'd0;
    la = 4'd0;
    for (int i = 15; i >= 0; i--) if (f[i]) fi = 4'(i);
    for (int i = 0; i < 16; i++) if (f[i]) la = 4'(i);
  endfunction

  // Start pulse accepted at edge k; n counts negedges after k.
  task automatic run_sweep(input string tag, input logic [15:0] t, input logic [4:0] o,
                           input logic a, input logic [3:0] fi, input logic [3:0] la,
                           input bit repulse);
    int lat1, lat3, n1, n3;
    lat1 = -1; lat3 = -1; n1 = 0; n3 = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, " busy after start"}, 32'(busy1 & busy3), 32'd1);
    for (int n = 1; n <= 72; n++) begin
      @(negedge clk);
      start = repulse && (n == 10);
      if (done1) begin n1++; lat1 = n; end
      if (done3) begin n3++; lat3 = n; end
    end
    start = 1'b0;
    check({tag, " s1 latency"}, 32'(lat1), 32'd32);
    check({tag, " s1 done count"}, 32'(n1), 32'd1);
    check({tag, " s3 latency"}, 32'(lat3), 32'd64);
    check({tag, " s3 done count"}, 32'(n3), 32'd1);
    check_results(tag, t, o, a, fi, la);
    $display("[TB] sweep %s table=%h ones=%0d", tag, tab1, ones1);
  endtask

  task automatic wait_idx1(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy1 && ({a1, b1, c1, d1} == target)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [15:0] t;
    logic [4:0] o;
    logic a;
    logic [3:0] fi, la;
    bit ok;
    int nd;

    vecs[0] = '{"expr",  16'h0000, 1'b1, 16'h0007, 5'd3,  1'b1, 4'd0,  4'd2};
    vecs[1] = '{"zero",  16'h0000, 1'b0, 16'h0000, 5'd0,  1'b0, 4'd0,  4'd0};
    vecs[2] = '{"ones",  16'hFFFF, 1'b0, 16'hFFFF, 5'd16, 1'b1, 4'd0,  4'd15};
    vecs[3] = '{"top",   16'h8000, 1'b0, 16'h8000, 5'd1,  1'b1, 4'd15, 4'd15};
    vecs[4] = '{"bot",   16'h0001, 1'b0, 16'h0001, 5'd1,  1'b1, 4'd0,  4'd0};
    vecs[5] = '{"mid",   16'h0A50, 1'b0, 16'h0A50, 5'd4,  1'b1, 4'd4,  4'd11};

    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy1 | busy3), 32'd0);
    check("reset done", 32'(done1 | done3), 32'd0);
    check("reset abcd", 32'({a1, b1, c1, d1, a3, b3, c3, d3}), 32'd0);
    check_results("reset", 16'h0, 5'd0, 1'b0, 4'd0, 4'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      func = vecs[i].f;
      use_expr = vecs[i].expr;
      run_sweep(vecs[i].name, vecs[i].t, vecs[i].o, vecs[i].a, vecs[i].fi, vecs[i].la, 1'b0);
    end
    use_expr = 1'b0;

    // Start re-pulsed mid-sweep is ignored.
    func = 16'h3C81;
    model(func, t, o, a, fi, la);
    run_sweep("repulse", t, o, a, fi, la, 1'b1);

    for (int r = 0; r < 6; r++) begin
      func = 16'($urandom);
      model(func, t, o, a, fi, la);
      run_sweep($sformatf("rand%0d", r), t, o, a, fi, la, 1'b0);
    end

    // Abort at idx=5 with Y=1: partial results must be wiped.
    func = 16'hFFFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idx1(4'd5, ok);
    check("abort reach idx5", 32'(ok), 32'd1);
    check("abort partial table", 32'(tab1), 32'h001F);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort busy", 32'(busy1 | busy3), 32'd0);
    check("abort abcd", 32'({a1, b1, c1, d1}), 32'd0);
    check_results("abort", 16'h0, 5'd0, 1'b0, 4'd0, 4'd0);
    nd = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (done1 || done3) nd++;
    end
    check("abort no done", 32'(nd), 32'd0);
    $display("[TB] abort at idx5 done_pulses=%0d", nd);
    model(func, t, o, a, fi, la);
    run_sweep("after abort", t, o, a, fi, la, 1'b0);

    // Asynchronous reset at idx=9, mid-cycle.
    func = 16'hFFFF;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idx1(4'd9, ok);
    check("reset reach idx9", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy1 | busy3), 32'd0);
    check("midreset abcd", 32'({a1, b1, c1, d1, a3, b3, c3, d3}), 32'd0);
    check_results("midreset", 16'h0, 5'd0, 1'b0, 4'd0, 4'd0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    ok = 1'b0;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (done1 || done3) nd++;
      if (busy1 || busy3) ok = 1'b1;
    end
    check("midreset no done", 32'(nd), 32'd0);
    check("midreset stays idle", 32'(ok), 32'd0);
    $display("[TB] mid-sweep reset done_pulses=%0d", nd);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
